// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the Mini SRC hardwired control unit: opcodes, ALU codes,
// sequencer states, instruction classes and the strobe bundle driven into the datapath.
package cpu_ctrl_pkg;

  localparam int unsigned OP_W   = 5;
  localparam int unsigned ALU_W  = 4;

  // Instruction field positions within IR
  localparam int unsigned OP_MSB = 31;
  localparam int unsigned RA_MSB = 26;
  localparam int unsigned RA_LSB = 23;
  localparam int unsigned RB_MSB = 22;
  localparam int unsigned RB_LSB = 19;
  localparam int unsigned RC_MSB = 18;
  localparam int unsigned RC_LSB = 15;

  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_SHR  = 5'b00101;
  localparam logic [OP_W-1:0] OP_SHRA = 5'b00110;
  localparam logic [OP_W-1:0] OP_SHL  = 5'b00111;
  localparam logic [OP_W-1:0] OP_ROR  = 5'b01000;
  localparam logic [OP_W-1:0] OP_ROL  = 5'b01001;
  localparam logic [OP_W-1:0] OP_AND  = 5'b01010;
  localparam logic [OP_W-1:0] OP_OR   = 5'b01011;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
  localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  localparam logic [ALU_W-1:0] ALU_NONE = 4'd0;
  localparam logic [ALU_W-1:0] ALU_ADD  = 4'd1;
  localparam logic [ALU_W-1:0] ALU_SUB  = 4'd2;
  localparam logic [ALU_W-1:0] ALU_SHR  = 4'd3;
  localparam logic [ALU_W-1:0] ALU_SHRA = 4'd4;
  localparam logic [ALU_W-1:0] ALU_SHL  = 4'd5;
  localparam logic [ALU_W-1:0] ALU_ROR  = 4'd6;
  localparam logic [ALU_W-1:0] ALU_ROL  = 4'd7;
  localparam logic [ALU_W-1:0] ALU_AND  = 4'd8;
  localparam logic [ALU_W-1:0] ALU_OR   = 4'd9;
  localparam logic [ALU_W-1:0] ALU_MUL  = 4'd10;
  localparam logic [ALU_W-1:0] ALU_DIV  = 4'd11;
  localparam logic [ALU_W-1:0] ALU_NEG  = 4'd12;
  localparam logic [ALU_W-1:0] ALU_NOT  = 4'd13;

  typedef enum logic [3:0] {
    ST_RST  = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_HALT = 4'd8
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU2    = 3'd0,
    CLS_MULDIV  = 3'd1,
    CLS_UNARY   = 3'd2,
    CLS_NOP     = 3'd3,
    CLS_HALT    = 3'd4,
    CLS_ILLEGAL = 3'd5
  } op_class_e;

  typedef struct packed {
    logic             pc_out;
    logic             zlow_out;
    logic             zhigh_out;
    logic             mdr_out;
    logic             mar_in;
    logic             pc_in;
    logic             mdr_in;
    logic             ir_in;
    logic             y_in;
    logic             z_in;
    logic             hi_in;
    logic             lo_in;
    logic             inc_pc;
    logic             read;
    logic             gra;
    logic             grb;
    logic             grc;
    logic             r_in;
    logic             r_out;
    logic             run;
    logic             illegal_op;
    logic [ALU_W-1:0] alu_op;
  } ctrl_t;

  // Classes whose first operand is staged through Y before the ALU step
  function automatic logic uses_y_path(op_class_e cls);
    return (cls == CLS_ALU2) || (cls == CLS_MULDIV);
  endfunction

endpackage

// File: rtl/op_decoder.sv
// Combinational opcode decode: instruction class and ALU operation for the
// latched opcode. Unlisted opcodes fall into the ILLEGAL class.
module op_decoder
  import cpu_ctrl_pkg::*;
(
  input  logic [OP_W-1:0]  opcode_i,
  output op_class_e        cls_o,
  output logic [ALU_W-1:0] alu_op_o
);

  always_comb begin
    cls_o    = CLS_ILLEGAL;
    alu_op_o = ALU_NONE;
    case (opcode_i)
      OP_ADD:  begin cls_o = CLS_ALU2;   alu_op_o = ALU_ADD;  end
      OP_SUB:  begin cls_o = CLS_ALU2;   alu_op_o = ALU_SUB;  end
      OP_SHR:  begin cls_o = CLS_ALU2;   alu_op_o = ALU_SHR;  end
      OP_SHRA: begin cls_o = CLS_ALU2;   alu_op_o = ALU_SHRA; end
      OP_SHL:  begin cls_o = CLS_ALU2;   alu_op_o = ALU_SHL;  end
      OP_ROR:  begin cls_o = CLS_ALU2;   alu_op_o = ALU_ROR;  end
      OP_ROL:  begin cls_o = CLS_ALU2;   alu_op_o = ALU_ROL;  end
      OP_AND:  begin cls_o = CLS_ALU2;   alu_op_o = ALU_AND;  end
      OP_OR:   begin cls_o = CLS_ALU2;   alu_op_o = ALU_OR;   end
      OP_MUL:  begin cls_o = CLS_MULDIV; alu_op_o = ALU_MUL;  end
      OP_DIV:  begin cls_o = CLS_MULDIV; alu_op_o = ALU_DIV;  end
      OP_NEG:  begin cls_o = CLS_UNARY;  alu_op_o = ALU_NEG;  end
      OP_NOT:  begin cls_o = CLS_UNARY;  alu_op_o = ALU_NOT;  end
      OP_NOP:  cls_o = CLS_NOP;
      OP_HALT: cls_o = CLS_HALT;
      default: cls_o = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the Mini SRC datapath: fetch (T0-T2) and
// execute (T3-T6) sequencing with strobes decoded from state and latched opcode.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned OPW  = 5,
  parameter int unsigned AOPW = 4
) (
  input  logic            clock,
  input  logic            clear,
  input  logic [31:0]     ir,
  input  logic            mem_ready,
  output logic            PCout,
  output logic            Zlowout,
  output logic            Zhighout,
  output logic            MDRout,
  output logic            MARin,
  output logic            PCin,
  output logic            MDRin,
  output logic            IRin,
  output logic            Yin,
  output logic            Zin,
  output logic            HIin,
  output logic            LOin,
  output logic            IncPC,
  output logic            Read,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rin,
  output logic            Rout,
  output logic [AOPW-1:0] alu_op,
  output logic            run,
  output logic            illegal_op
);

  state_e           state_q, state_d;
  logic [OPW-1:0]   op_q, op_d;
  op_class_e        cls;
  logic [ALU_W-1:0] dec_alu;
  ctrl_t            ctrl;

  // Register fields are consumed by the datapath's register-select logic, not here
  logic unused_ir_fields;
  assign unused_ir_fields = ^{ir[RA_MSB:RA_LSB], ir[RB_MSB:RB_LSB],
                              ir[RC_MSB:RC_LSB], ir[RC_LSB-1:0]};

  op_decoder u_op_decoder (
    .opcode_i (OP_W'(op_q)),
    .cls_o    (cls),
    .alu_op_o (dec_alu)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= ST_RST;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Opcode captured as IR is loaded; execute steps never look at live ir
  assign op_d = (state_q == ST_T2) ? ir[OP_MSB -: OPW] : op_q;

  always_comb begin
    state_d  = state_q;
    ctrl     = '0;
    ctrl.run = 1'b1;
    case (state_q)
      ST_RST: state_d = ST_T0;
      ST_T0: begin
        ctrl.pc_out = 1'b1;
        ctrl.mar_in = 1'b1;
        ctrl.inc_pc = 1'b1;
        ctrl.z_in   = 1'b1;
        state_d     = ST_T1;
      end
      ST_T1: begin
        ctrl.zlow_out = 1'b1;
        ctrl.pc_in    = 1'b1;
        ctrl.read     = 1'b1;
        ctrl.mdr_in   = 1'b1;
        if (mem_ready) state_d = ST_T2;
      end
      ST_T2: begin
        ctrl.mdr_out = 1'b1;
        ctrl.ir_in   = 1'b1;
        state_d      = ST_T3;
      end
      ST_T3: begin
        if (uses_y_path(cls)) begin
          ctrl.grb   = 1'b1;
          ctrl.r_out = 1'b1;
          ctrl.y_in  = 1'b1;
          state_d    = ST_T4;
        end else if (cls == CLS_UNARY) begin
          ctrl.grb    = 1'b1;
          ctrl.r_out  = 1'b1;
          ctrl.z_in   = 1'b1;
          ctrl.alu_op = dec_alu;
          state_d     = ST_T4;
        end else if (cls == CLS_HALT) begin
          state_d = ST_HALT;
        end else begin
          ctrl.illegal_op = (cls == CLS_ILLEGAL);
          state_d         = ST_T0;
        end
      end
      ST_T4: begin
        if (cls == CLS_UNARY) begin
          ctrl.zlow_out = 1'b1;
          ctrl.gra      = 1'b1;
          ctrl.r_in     = 1'b1;
          state_d       = ST_T0;
        end else begin
          ctrl.grc    = 1'b1;
          ctrl.r_out  = 1'b1;
          ctrl.z_in   = 1'b1;
          ctrl.alu_op = dec_alu;
          state_d     = ST_T5;
        end
      end
      ST_T5: begin
        ctrl.zlow_out = 1'b1;
        if (cls == CLS_MULDIV) begin
          ctrl.lo_in = 1'b1;
          state_d    = ST_T6;
        end else begin
          ctrl.gra  = 1'b1;
          ctrl.r_in = 1'b1;
          state_d   = ST_T0;
        end
      end
      ST_T6: begin
        ctrl.zhigh_out = 1'b1;
        ctrl.hi_in     = 1'b1;
        state_d        = ST_T0;
      end
      ST_HALT: ctrl.run = 1'b0;
      default: state_d = ST_RST;
    endcase
  end

  assign PCout      = ctrl.pc_out;
  assign Zlowout    = ctrl.zlow_out;
  assign Zhighout   = ctrl.zhigh_out;
  assign MDRout     = ctrl.mdr_out;
  assign MARin      = ctrl.mar_in;
  assign PCin       = ctrl.pc_in;
  assign MDRin      = ctrl.mdr_in;
  assign IRin       = ctrl.ir_in;
  assign Yin        = ctrl.y_in;
  assign Zin        = ctrl.z_in;
  assign HIin       = ctrl.hi_in;
  assign LOin       = ctrl.lo_in;
  assign IncPC      = ctrl.inc_pc;
  assign Read       = ctrl.read;
  assign Gra        = ctrl.gra;
  assign Grb        = ctrl.grb;
  assign Grc        = ctrl.grc;
  assign Rin        = ctrl.r_in;
  assign Rout       = ctrl.r_out;
  assign alu_op     = AOPW'(ctrl.alu_op);
  assign run        = ctrl.run;
  assign illegal_op = ctrl.illegal_op;

endmodule
